i2c_cfg_sequencer: RTL and testbench

- Upstream command source for `i2c_master`: after one start pulse, walks a table of `{reg_addr, data}` words in an external synchronous ROM.
- Issues one `i2c_master` register write per entry, waits for completion and checks NACK status.
- Retries failed writes, inserts programmed delays, and reports done or error.
- Used to bring up the sensor's register set after reset; the slave address is tied at the `i2c_master` instance.

---
 rtl/i2c_cfg_sequencer_if.sv | 33 +++
 rtl/i2c_cfg_sequencer.sv | 162 ++++++++++++++++
 tb/tb_i2c_cfg_sequencer.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_cfg_sequencer_if.sv
// ============================================================================
//  Module   : i2c_cfg_sequencer_if
//  Brief    : Bus bundle between the config sequencer, its table ROM and the
//             downstream i2c_master (names seen from the sequencer side).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface i2c_cfg_sequencer_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] o_rom_addr;
  logic [15:0]       i_rom_data;
  logic              o_wr;
  logic [7:0]        o_reg_addr;
  logic [7:0]        o_wdata;
  logic              i_busy;
  logic              i_nack_slave;
  logic              i_nack_addr;
  logic              i_nack_data;

  modport master (
    output o_rom_addr, o_wr, o_reg_addr, o_wdata,
    input  i_rom_data, i_busy, i_nack_slave, i_nack_addr, i_nack_data
  );

  modport slave (
    input  o_rom_addr, o_wr, o_reg_addr, o_wdata,
    output i_rom_data, i_busy, i_nack_slave, i_nack_addr, i_nack_data
  );
endinterface

`default_nettype wire

// File: rtl/i2c_cfg_sequencer.sv
// ============================================================================
//  Module   : i2c_cfg_sequencer
//  Brief    : Walks a {reg_addr,data} ROM table and issues i2c_master register
//             writes with retry, delay entries and done/error reporting.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_cfg_sequencer #(
  parameter int CLK_FREQ      = 25_000_000,
  parameter int DELAY_MS      = 10,
  parameter int ADDR_W        = 8,
  parameter int MAX_RETRY     = 3,
  parameter int START_TIMEOUT = 16
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_start,
  i2c_cfg_sequencer_if.master bus,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error,
  output logic [ADDR_W-1:0] o_err_index
);

  localparam int c_DLY_CYC = CLK_FREQ / 1000 * DELAY_MS;
  localparam int c_DLY_W   = (c_DLY_CYC > 1) ? $clog2(c_DLY_CYC) : 1;
  localparam int c_TO_W    = (START_TIMEOUT > 2) ? $clog2(START_TIMEOUT) : 1;
  localparam int c_RTY_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [c_DLY_W-1:0] c_DLY_LAST = c_DLY_W'(c_DLY_CYC - 1);
  // WAIT_START is entered the cycle after o_wr, so it gets one cycle less
  localparam logic [c_TO_W-1:0]  c_TO_LAST  = c_TO_W'(START_TIMEOUT - 2);
  localparam logic [c_RTY_W-1:0] c_RTY_MAX  = c_RTY_W'(MAX_RETRY);
  localparam logic [15:0]        c_EOT      = 16'hFFFF;
  localparam logic [15:0]        c_DLY_WORD = 16'hFFF0;

  localparam logic [3:0] S_IDLE       = 4'd0;
  localparam logic [3:0] S_FETCH      = 4'd1;
  localparam logic [3:0] S_DECODE     = 4'd2;
  localparam logic [3:0] S_ISSUE      = 4'd3;
  localparam logic [3:0] S_WAIT_START = 4'd4;
  localparam logic [3:0] S_WAIT_DONE  = 4'd5;
  localparam logic [3:0] S_CHECK      = 4'd6;
  localparam logic [3:0] S_DELAY      = 4'd7;
  localparam logic [3:0] S_DONE       = 4'd8;
  localparam logic [3:0] S_ERROR      = 4'd9;

  logic [3:0]         r_state;
  logic [ADDR_W-1:0]  r_rom_addr;
  logic [7:0]         r_reg_addr;
  logic [7:0]         r_wdata;
  logic [c_RTY_W-1:0] r_retry;
  logic [c_DLY_W-1:0] r_dly;
  logic [c_TO_W-1:0]  r_to;
  logic [ADDR_W-1:0]  r_err_index;
  logic               w_nack;
  logic               w_last;

  assign w_nack = bus.i_nack_slave | bus.i_nack_addr | bus.i_nack_data;
  assign w_last = &r_rom_addr;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state     <= S_IDLE;
      r_rom_addr  <= '0;
      r_reg_addr  <= '0;
      r_wdata     <= '0;
      r_retry     <= '0;
      r_dly       <= '0;
      r_to        <= '0;
      r_err_index <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (i_start) begin
            r_state     <= S_FETCH;
            r_rom_addr  <= '0;
            r_retry     <= '0;
            r_err_index <= '0;
          end
        end
        S_FETCH: r_state <= S_DECODE;
        S_DECODE: begin
          if (bus.i_rom_data == c_EOT) begin
            r_state <= S_DONE;
          end else if (bus.i_rom_data == c_DLY_WORD) begin
            r_dly   <= c_DLY_LAST;
            r_state <= S_DELAY;
          end else begin
            r_reg_addr <= bus.i_rom_data[15:8];
            r_wdata    <= bus.i_rom_data[7:0];
            r_state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_to    <= '0;
          r_state <= S_WAIT_START;
        end
        S_WAIT_START: begin
          if (bus.i_busy) begin
            r_state <= S_WAIT_DONE;
          end else if (r_to == c_TO_LAST) begin
            r_err_index <= r_rom_addr;
            r_state     <= S_ERROR;
          end else begin
            r_to <= r_to + 1'b1;
          end
        end
        S_WAIT_DONE: begin
          if (!bus.i_busy) r_state <= S_CHECK;
        end
        S_CHECK: begin
          if (w_nack) begin
            if (r_retry < c_RTY_MAX) begin
              r_retry <= r_retry + 1'b1;
              r_state <= S_ISSUE;
            end else begin
              r_err_index <= r_rom_addr;
              r_state     <= S_ERROR;
            end
          end else begin
            r_retry <= '0;
            if (w_last) begin
              r_state <= S_DONE;
            end else begin
              r_rom_addr <= r_rom_addr + 1'b1;
              r_state    <= S_FETCH;
            end
          end
        end
        S_DELAY: begin
          if (r_dly == '0) begin
            r_retry <= '0;
            if (w_last) begin
              r_state <= S_DONE;
            end else begin
              r_rom_addr <= r_rom_addr + 1'b1;
              r_state    <= S_FETCH;
            end
          end else begin
            r_dly <= r_dly - 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Status and strobe decode straight from state so reset clears them at once
  assign o_busy         = (r_state != S_IDLE) && (r_state != S_DONE) && (r_state != S_ERROR);
  assign o_done         = (r_state == S_DONE);
  assign o_error        = (r_state == S_ERROR);
  assign o_err_index    = r_err_index;
  assign bus.o_wr       = (r_state == S_ISSUE);
  assign bus.o_rom_addr = r_rom_addr;
  assign bus.o_reg_addr = r_reg_addr;
  assign bus.o_wdata    = r_wdata;

endmodule

`default_nettype wire

// File: tb/tb_i2c_cfg_sequencer.sv
// ============================================================================
//  Module   : tb_i2c_cfg_sequencer
//  Brief    : Directed self-checking bench with ROM and i2c_master models.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_i2c_cfg_sequencer;

  localparam int BUSY_A = 40;
  localparam int BUSY_B = 10;

  logic clk    = 1'b0;
  logic rstn   = 1'b0;
  logic start_a = 1'b0;
  logic start_b = 1'b0;
  int   cyc    = 0;
  int   n_run  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  i2c_cfg_sequencer_if #(.ADDR_W(8)) bus_a ();
  i2c_cfg_sequencer_if #(.ADDR_W(2)) bus_b ();

  logic       busy_a, done_a, err_a;
  logic [7:0] eidx_a;
  logic       busy_b, done_b, err_b;
  logic [1:0] eidx_b;

  i2c_cfg_sequencer #(.CLK_FREQ(100_000), .DELAY_MS(1), .ADDR_W(8),
                      .MAX_RETRY(3), .START_TIMEOUT(16)) dut_a (
    .i_clk(clk), .i_rstn(rstn), .i_start(start_a), .bus(bus_a),
    .o_busy(busy_a), .o_done(done_a), .o_error(err_a), .o_err_index(eidx_a)
  );

  i2c_cfg_sequencer #(.CLK_FREQ(100_000), .DELAY_MS(1), .ADDR_W(2),
                      .MAX_RETRY(3), .START_TIMEOUT(16)) dut_b (
    .i_clk(clk), .i_rstn(rstn), .i_start(start_b), .bus(bus_b),
    .o_busy(busy_b), .o_done(done_b), .o_error(err_b), .o_err_index(eidx_b)
  );

  // Synchronous ROMs: data valid the cycle after the address
  logic [15:0] rom_a [256];
  logic [15:0] rom_b [4];
  always @(posedge clk) bus_a.i_rom_data <= rom_a[bus_a.o_rom_addr];
  always @(posedge clk) bus_b.i_rom_data <= rom_b[bus_b.o_rom_addr];

  // Master model A: busy for BUSY_A cycles, NACKs writes to nack_reg_a while budget remains
  logic       mst_en_a    = 1'b1;
  logic [7:0] nack_reg_a  = 8'h00;
  int         nack_kind_a = 0;
  int         nack_lim_a  = 0;
  int         nack_used_a = 0;
  int         bcnt_a;
  logic       pend_a;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bus_a.i_busy <= 1'b0; bus_a.i_nack_slave <= 1'b0;
      bus_a.i_nack_addr <= 1'b0; bus_a.i_nack_data <= 1'b0;
      bcnt_a <= 0; pend_a <= 1'b0;
    end else if (bus_a.o_wr && mst_en_a) begin
      bus_a.i_busy <= 1'b1; bcnt_a <= BUSY_A;
      bus_a.i_nack_slave <= 1'b0; bus_a.i_nack_addr <= 1'b0; bus_a.i_nack_data <= 1'b0;
      pend_a <= (bus_a.o_reg_addr == nack_reg_a) && (nack_used_a < nack_lim_a);
      if ((bus_a.o_reg_addr == nack_reg_a) && (nack_used_a < nack_lim_a))
        nack_used_a <= nack_used_a + 1;
    end else if (bcnt_a > 0) begin
      bcnt_a <= bcnt_a - 1;
      if (bcnt_a == 1) begin
        bus_a.i_busy       <= 1'b0;
        bus_a.i_nack_slave <= pend_a && (nack_kind_a == 0);
        bus_a.i_nack_addr  <= pend_a && (nack_kind_a == 1);
        bus_a.i_nack_data  <= pend_a && (nack_kind_a == 2);
      end
    end
  end

  int bcnt_b;
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bus_b.i_busy <= 1'b0; bus_b.i_nack_slave <= 1'b0;
      bus_b.i_nack_addr <= 1'b0; bus_b.i_nack_data <= 1'b0;
      bcnt_b <= 0;
    end else if (bus_b.o_wr) begin
      bus_b.i_busy <= 1'b1; bcnt_b <= BUSY_B;
    end else if (bcnt_b > 0) begin
      bcnt_b <= bcnt_b - 1;
      if (bcnt_b == 1) bus_b.i_busy <= 1'b0;
    end
  end

  // Write loggers: {reg,data} and the cycle of every o_wr pulse
  logic [15:0] log_a [64];
  int          wcyc_a [64];
  int          wn_a = 0;
  logic [15:0] log_b [64];
  int          wn_b = 0;

  always @(posedge clk) begin
    if (bus_a.o_wr) begin
      log_a[wn_a % 64]  <= {bus_a.o_reg_addr, bus_a.o_wdata};
      wcyc_a[wn_a % 64] <= cyc;
      wn_a <= wn_a + 1;
    end
    if (bus_b.o_wr) begin
      log_b[wn_b % 64] <= {bus_b.o_reg_addr, bus_b.o_wdata};
      wn_b <= wn_b + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_a(output int scyc);
    @(negedge clk); start_a = 1'b1; scyc = cyc;
    @(negedge clk); start_a = 1'b0;
  endtask

  task automatic wait_term_a(input int budget, input string tag);
    int k = 0;
    while (!(done_a || err_a) && k < budget) begin @(negedge clk); k++; end
    check(tag, 32'(done_a || err_a), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s, base, k, ecyc;
    for (int i = 0; i < 256; i++) rom_a[i] = 16'hFFFF;
    rom_b[0] = 16'h1280; rom_b[1] = 16'h1101; rom_b[2] = 16'h1302; rom_b[3] = 16'h1403;

    repeat (3) @(negedge clk);
    check("rst_busy",  32'(busy_a), 32'd0);
    check("rst_flags", {30'd0, done_a, err_a}, 32'd0);
    check("rst_wr",    32'(bus_a.o_wr), 32'd0);
    check("rst_bus",   {8'd0, bus_a.o_rom_addr, bus_a.o_reg_addr, bus_a.o_wdata}, 32'd0);
    check("rst_eidx",  32'(eidx_a), 32'd0);
    rstn = 1'b1;
    @(negedge clk);

    // Basic table, plus a start pulse while busy that must be ignored
    rom_a[0] = 16'h1280; rom_a[1] = 16'h1101; rom_a[2] = 16'hFFFF;
    base = wn_a;
    pulse_a(s);
    check("t1_busy_lat", 32'(busy_a), 32'd1);
    @(negedge clk); @(negedge clk);
    check("t1_wr_lat", 32'(bus_a.o_wr), 32'd1);
    check("t1_wr_data", {16'd0, bus_a.o_reg_addr, bus_a.o_wdata}, 32'h1280);
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    wait_term_a(2000, "t1_term");
    check("t1_done", {30'd0, done_a, err_a}, 32'h2);
    check("t1_busy", 32'(busy_a), 32'd0);
    check("t1_nwr", 32'(wn_a - base), 32'd2);
    check("t1_log0", 32'(log_a[base]), 32'h1280);
    check("t1_log1", 32'(log_a[base + 1]), 32'h1101);
    check("t1_gap", 32'(wcyc_a[base + 1] - wcyc_a[base]), 32'(BUSY_A + 5));

    // Delay entry: 100 cycles in DELAY, so start+105 for the first write
    rom_a[0] = 16'hFFF0; rom_a[1] = 16'h1280; rom_a[2] = 16'hFFFF;
    base = wn_a;
    pulse_a(s);
    check("t2_done_clr", 32'(done_a), 32'd0);
    wait_term_a(2000, "t2_term");
    check("t2_nwr", 32'(wn_a - base), 32'd1);
    check("t2_lat", 32'(wcyc_a[base] - s), 32'd105);
    check("t2_log", 32'(log_a[base]), 32'h1280);
    check("t2_done", {30'd0, done_a, err_a}, 32'h2);

    // Retry recovers: two address NACKs on entry 1
    rom_a[0] = 16'h1280; rom_a[1] = 16'h1101; rom_a[2] = 16'hFFFF;
    nack_reg_a = 8'h11; nack_kind_a = 1; nack_lim_a = nack_used_a + 2;
    base = wn_a;
    pulse_a(s);
    wait_term_a(2000, "t3_term");
    check("t3_nwr", 32'(wn_a - base), 32'd4);
    check("t3_try1", 32'(log_a[base + 1]), 32'h1101);
    check("t3_try2", 32'(log_a[base + 2]), 32'h1101);
    check("t3_try3", 32'(log_a[base + 3]), 32'h1101);
    check("t3_done", {30'd0, done_a, err_a}, 32'h2);

    // Retry exhausted: data NACK forever on entry 2
    rom_a[2] = 16'h1302; rom_a[3] = 16'hFFFF;
    nack_reg_a = 8'h13; nack_kind_a = 2; nack_lim_a = nack_used_a + 1000;
    base = wn_a;
    pulse_a(s);
    wait_term_a(2000, "t4_term");
    check("t4_nwr", 32'(wn_a - base), 32'd6);
    check("t4_first", 32'(log_a[base + 2]), 32'h1302);
    check("t4_last", 32'(log_a[base + 5]), 32'h1302);
    check("t4_err", {30'd0, done_a, err_a}, 32'h1);
    check("t4_eidx", 32'(eidx_a), 32'd2);
    check("t4_busy", 32'(busy_a), 32'd0);
    nack_lim_a = nack_used_a;

    // Master never busy: error START_TIMEOUT cycles after o_wr
    mst_en_a = 1'b0;
    rom_a[0] = 16'h1280; rom_a[1] = 16'hFFFF;
    base = wn_a;
    pulse_a(s);
    check("t5_err_clr", {22'd0, err_a, eidx_a, busy_a}, 32'h1);
    k = 0;
    while (!err_a && k < 100) begin @(negedge clk); k++; end
    ecyc = cyc;
    check("t5_err", 32'(err_a), 32'd1);
    check("t5_tmo", 32'(ecyc - wcyc_a[base]), 32'd16);
    check("t5_eidx", 32'(eidx_a), 32'd0);
    check("t5_nwr", 32'(wn_a - base), 32'd1);
    mst_en_a = 1'b1;

    // Asynchronous reset in WAIT_DONE, then no resume
    pulse_a(s);
    repeat (10) @(negedge clk);
    check("t6_inflight", {30'd0, busy_a, bus_a.i_busy}, 32'h3);
    rstn = 1'b0;
    #1;
    check("t6_rst_busy", {29'd0, busy_a, done_a, err_a}, 32'd0);
    check("t6_rst_bus", {7'd0, bus_a.o_wr, bus_a.o_rom_addr, bus_a.o_reg_addr, bus_a.o_wdata}, 32'd0);
    @(negedge clk); rstn = 1'b1;
    repeat (5) @(negedge clk);
    check("t6_no_resume", {30'd0, busy_a, bus_a.o_wr}, 32'd0);

    // Implicit end of table with ADDR_W=2
    @(negedge clk); start_b = 1'b1;
    @(negedge clk); start_b = 1'b0;
    k = 0;
    while (!(done_b || err_b) && k < 500) begin @(negedge clk); k++; end
    check("t7_done", {30'd0, done_b, err_b}, 32'h2);
    check("t7_nwr", 32'(wn_b), 32'd4);
    check("t7_log3", 32'(log_b[3]), 32'h1403);
    repeat (20) @(negedge clk);
    check("t7_no_wrap", {31'd0, busy_b} + 32'(wn_b), 32'd4);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
